// File: rtl/updown_counter_param_pkg.sv
// Shared types and encodings for the parametrised up/down counter.
package updown_counter_param_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle of the counter; master drives controls, slave is the counter.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic             updown;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic             mode;
    logic             clr_flags;
    logic [WIDTH-1:0] data_out;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             at_limit;
    logic             at_zero;

    modport master (
        output en, load, updown, data, step, limit, mode, clr_flags,
        input  data_out, tc, ovf, unf, at_limit, at_zero
    );

    modport slave (
        input  en, load, updown, data, step, limit, mode, clr_flags,
        output data_out, tc, ovf, unf, at_limit, at_zero
    );
endinterface

// File: rtl/updown_counter_param_next_calc.sv
// Combinational next-count and event computation: load, range clamp, step, wrap/saturate.
module updown_counter_param_next_calc
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt,
    output logic             evt,
    output logic             ovf_set,
    output logic             unf_set
);

    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   lim1;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_wrap;

    always_comb begin
        s       = (step > limit) ? limit : step;
        sum     = {1'b0, cur} + {1'b0, s};
        lim1    = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
        up_wrap = sum - lim1;
        dn_wrap = {1'b0, cur} + lim1 - {1'b0, s};

        nxt     = cur;
        evt     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (load) begin
            nxt = (data > limit) ? limit : data;
        end else if (cur > limit) begin
            nxt = limit;
        end else if (en && (step != '0)) begin
            // With a zero limit the range is {0}: every nonzero request overruns it.
            if (limit == '0) begin
                nxt     = '0;
                evt     = 1'b1;
                ovf_set = (updown == DIR_UP);
                unf_set = (updown == DIR_DOWN);
            end else if (updown == DIR_UP) begin
                if (sum <= {1'b0, limit}) begin
                    nxt = sum[WIDTH-1:0];
                end else begin
                    evt     = 1'b1;
                    ovf_set = 1'b1;
                    nxt     = (mode == MODE_SAT) ? limit : up_wrap[WIDTH-1:0];
                end
            end else begin
                if (s <= cur) begin
                    nxt = cur - s;
                end else begin
                    evt     = 1'b1;
                    unf_set = 1'b1;
                    nxt     = (mode == MODE_SAT) ? '0 : dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised load/up/down counter with programmable limit, wrap/saturate, tc and sticky flags.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    updown_counter_param_if.slave  bus
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] nxt;
    logic             evt;
    logic             ovf_set;
    logic             unf_set;

    updown_counter_param_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .cur     (data_out_q),
        .en      (bus.en),
        .load    (bus.load),
        .updown  (bus.updown),
        .data    (bus.data),
        .step    (bus.step),
        .limit   (bus.limit),
        .mode    (bus.mode),
        .nxt     (nxt),
        .evt     (evt),
        .ovf_set (ovf_set),
        .unf_set (unf_set)
    );

    // A flag being set in the same cycle as clr_flags stays set.
    always_comb begin
        data_out_d = nxt;
        tc_d       = evt;
        ovf_d      = ovf_set ? 1'b1 : (bus.clr_flags ? 1'b0 : ovf_q);
        unf_d      = unf_set ? 1'b1 : (bus.clr_flags ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= RST_V;
            tc_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            tc_q       <= tc_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.tc       = tc_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.at_limit = (data_out_q == bus.limit);
    assign bus.at_zero  = (data_out_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4, RST_VAL=0).
module tb_updown_counter_param;
    import updown_counter_param_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    updown_counter_param_if #(.WIDTH(4)) bus ();

    updown_counter_param #(.WIDTH(4), .RST_VAL(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] d, input logic t,
                          input logic o, input logic u);
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(d));
        chk({tag, ".tc"},       32'(bus.tc),       32'(t));
        chk({tag, ".ovf"},      32'(bus.ovf),      32'(o));
        chk({tag, ".unf"},      32'(bus.unf),      32'(u));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.en = 0; bus.load = 0; bus.updown = DIR_UP; bus.data = 0;
        bus.step = 0; bus.limit = 0; bus.mode = MODE_WRAP; bus.clr_flags = 0;

        #1;
        chk_st("reset", 4'd0, 0, 0, 0);
        chk("reset.at_zero", 32'(bus.at_zero), 32'd1);
        tick();
        tick();
        rst = 1'b1;

        // wrap: load 8, up 3 with limit 9 -> 1
        bus.limit = 4'd9; bus.load = 1; bus.data = 4'd8;
        tick();
        chk_st("load8", 4'd8, 0, 0, 0);
        bus.load = 0; bus.en = 1; bus.updown = DIR_UP; bus.step = 4'd3;
        tick();
        chk_st("wrap_up", 4'd1, 1, 1, 0);
        bus.en = 0;
        tick();
        chk_st("hold_after_wrap", 4'd1, 0, 1, 0);

        // clr_flags together with a new wrap: set wins
        bus.load = 1; bus.data = 4'd8;
        tick();
        bus.load = 0; bus.en = 1; bus.clr_flags = 1;
        tick();
        chk_st("clr_vs_set", 4'd1, 1, 1, 0);
        bus.en = 0;
        tick();
        chk_st("clr_alone", 4'd1, 0, 0, 0);
        bus.clr_flags = 0;

        // step larger than limit uses limit: 5 + 9 -> 14 - 10 = 4
        bus.load = 1; bus.data = 4'd5;
        tick();
        bus.load = 0; bus.en = 1; bus.step = 4'd15;
        tick();
        chk_st("big_step_wrap", 4'd4, 1, 1, 0);
        bus.step = 4'd0;
        tick();
        chk_st("zero_step", 4'd4, 0, 1, 0);
        bus.clr_flags = 1; bus.en = 0;
        tick();
        bus.clr_flags = 0;

        // saturate down
        bus.mode = MODE_SAT; bus.load = 1; bus.data = 4'd2;
        tick();
        bus.load = 0; bus.en = 1; bus.updown = DIR_DOWN; bus.step = 4'd3;
        tick();
        chk_st("sat_down", 4'd0, 1, 0, 1);
        tick();
        chk_st("sat_down_again", 4'd0, 1, 0, 1);
        chk("sat_down.at_zero", 32'(bus.at_zero), 32'd1);

        // saturate up from limit
        bus.updown = DIR_UP; bus.load = 1; bus.data = 4'd8; bus.en = 0;
        tick();
        bus.load = 0; bus.en = 1; bus.step = 4'd2;
        tick();
        chk_st("sat_up", 4'd9, 1, 1, 1);
        tick();
        chk_st("sat_up_at_limit", 4'd9, 1, 1, 1);

        // load clamp and range clamp
        bus.mode = MODE_WRAP; bus.en = 0; bus.load = 1; bus.data = 4'd12;
        tick();
        chk_st("load_clamp", 4'd9, 0, 1, 1);
        chk("load_clamp.at_limit", 32'(bus.at_limit), 32'd1);
        bus.load = 0; bus.limit = 4'd5;
        #1;
        chk("lower_limit.at_limit", 32'(bus.at_limit), 32'd0);
        tick();
        chk_st("range_clamp", 4'd5, 0, 1, 1);
        chk("range_clamp.at_limit", 32'(bus.at_limit), 32'd1);

        // async reset mid-count
        bus.limit = 4'd9; bus.load = 1; bus.data = 4'd6;
        tick();
        bus.load = 0; bus.en = 1; bus.updown = DIR_UP; bus.step = 4'd1;
        tick();
        chk_st("count_7", 4'd7, 0, 1, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_st("async_rst", 4'd0, 0, 0, 0);
        #1;
        rst = 1'b1;
        tick();
        chk_st("resume", 4'd1, 0, 0, 0);

        // wrap down from 0 at full range
        bus.en = 0; bus.limit = 4'd15; bus.load = 1; bus.data = 4'd0;
        tick();
        bus.load = 0; bus.en = 1; bus.updown = DIR_DOWN; bus.step = 4'd1;
        tick();
        chk_st("wrap_down", 4'd15, 1, 0, 1);
        bus.en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_st("en0_hold", 4'd15, 0, 0, 1);
        end

        // limit=0: clamp, then every nonzero step is an event
        bus.limit = 4'd0; bus.updown = DIR_UP; bus.step = 4'd5;
        tick();
        chk_st("lim0_clamp", 4'd0, 0, 0, 1);
        bus.en = 1;
        tick();
        chk_st("lim0_evt", 4'd0, 1, 1, 1);
        bus.en = 0;
        tick();
        chk_st("lim0_idle", 4'd0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
